// File: rtl/tt_host_pkg.sv
// Shared types and constants for the Tiny Tapeout host sequencer.
// The optional result checker is enabled with the TT_HOST_CHECK_EN macro.
package tt_host_pkg;

    localparam int DATA_W         = 8;
    localparam int CNT_W          = 8;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_LATENCY    = 2;

    typedef enum logic [2:0] {
        DUT_RST,
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/tt_host_delay_cnt.sv
// Loadable down-counter shared by the DUT reset hold and the latency wait.
// It comes out of reset preloaded with INIT so the reset hold starts at once.
module tt_host_delay_cnt #(
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tt_host_sequencer.sv
// Host-side sequencer that resets a Tiny Tapeout DUT, drives one operand pair and
// samples the result LATENCY cycles later. Define TT_HOST_CHECK_EN for the sum checker.
module tt_host_sequencer
    import tt_host_pkg::*;
#(
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
`ifdef TT_HOST_CHECK_EN
    output logic              rsp_err,
    output logic [DATA_W-1:0] err_count,
`endif
    output logic [DATA_W-1:0] rsp_data,
    output logic              dut_ena,
    output logic              dut_rst_n,
    output logic [DATA_W-1:0] dut_ui_in,
    output logic [DATA_W-1:0] dut_uio_in,
    input  logic [DATA_W-1:0] dut_uo_out,
    input  logic [DATA_W-1:0] dut_uio_out,
    input  logic [DATA_W-1:0] dut_uio_oe
);

    // WAIT lasts load value + 1 cycles, so LATENCY-2 gives LATENCY-1 wait cycles.
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t state;
    logic   cnt_load;
    logic   cnt_tick;
    logic   cnt_done;
    logic   unused_pins;

`ifdef TT_HOST_CHECK_EN
    logic [DATA_W-1:0] expected;
`endif

    assign cnt_load    = (state == DRIVE);
    assign cnt_tick    = (state == DUT_RST) || (state == WAIT);
    assign unused_pins = ^dut_uio_out;

    tt_host_delay_cnt #(
        .CNT_W (CNT_W),
        .INIT  (RST_LOAD)
    ) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .tick     (cnt_tick),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DUT_RST;
            op_ready   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            dut_ena    <= 1'b0;
            dut_rst_n  <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
`ifdef TT_HOST_CHECK_EN
            expected   <= '0;
            rsp_err    <= 1'b0;
            err_count  <= '0;
`endif
        end else begin
            dut_ena <= 1'b1;
            case (state)
                DUT_RST: begin
                    if (cnt_done) begin
                        state     <= IDLE;
                        dut_rst_n <= 1'b1;
                        op_ready  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (op_valid) begin
                        state      <= DRIVE;
                        op_ready   <= 1'b0;
                        dut_ui_in  <= op_a;
                        // Bidirectional pins the DUT is driving must not be fought.
                        dut_uio_in <= op_b & ~dut_uio_oe;
`ifdef TT_HOST_CHECK_EN
                        expected   <= op_a + op_b;
`endif
                    end
                end
                DRIVE: begin
                    state <= (LATENCY > 1) ? WAIT : CAPTURE;
                end
                WAIT: begin
                    if (cnt_done) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= dut_uo_out;
`ifdef TT_HOST_CHECK_EN
                    rsp_err   <= (dut_uo_out != expected);
                    if ((dut_uo_out != expected) && (err_count != '1)) begin
                        err_count <= err_count + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        op_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= DUT_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_host_sequencer.sv
// Directed self-checking bench for tt_host_sequencer with a combinational adder DUT model.
// Build with TT_HOST_CHECK_EN defined to also exercise the sum checker.
module tb_tt_host_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       dut_ena;
    logic       dut_rst_n;
    logic [7:0] dut_ui_in;
    logic [7:0] dut_uio_in;
    logic [7:0] dut_uo_out;
    logic [7:0] dut_uio_out = 8'hA5;
    logic [7:0] dut_uio_oe = 8'h00;
    logic       corrupt = 1'b0;
`ifdef TT_HOST_CHECK_EN
    logic       rsp_err;
    logic [7:0] err_count;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    int         lat;
    int         low;
    bit         saw_rsp;
    bit         stable;
    logic [7:0] seen_ui;
    logic [7:0] seen_uio;

    always #5 clk = ~clk;

    // Adder standing in for the user design; corrupt forces a wrong answer.
    assign dut_uo_out = corrupt ? 8'h00 : (dut_ui_in + dut_uio_in);

    tt_host_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
`ifdef TT_HOST_CHECK_EN
        .rsp_err     (rsp_err),
        .err_count   (err_count),
`endif
        .rsp_data    (rsp_data),
        .dut_ena     (dut_ena),
        .dut_rst_n   (dut_rst_n),
        .dut_ui_in   (dut_ui_in),
        .dut_uio_in  (dut_uio_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers one operand pair from a negedge and waits (bounded) for the response.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int cycles);
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(negedge clk);
        cycles   = 1;
        op_valid = 1'b0;
        seen_ui  = dut_ui_in;
        seen_uio = dut_uio_in;
        while (rsp_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Counts cycles the DUT is enabled but held in reset, after rst is released.
    task automatic waitDutReset(output int low_cycles, output bit rsp_seen);
        low_cycles = 0;
        rsp_seen   = 1'b0;
        for (int i = 0; i < 50 && dut_rst_n !== 1'b1; i++) begin
            @(negedge clk);
            if (dut_rst_n === 1'b0 && dut_ena === 1'b1) low_cycles++;
            if (rsp_valid === 1'b1) rsp_seen = 1'b1;
        end
    endtask

    initial begin
        $display("[TB] starting tt_host_sequencer bench");

        repeat (3) @(negedge clk);
        checkOutput("rst_op_ready", op_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_dut_rst_n", dut_rst_n, 0);
        checkOutput("rst_dut_ena", dut_ena, 0);
        checkOutput("rst_ui_in", dut_ui_in, 0);
        checkOutput("rst_uio_in", dut_uio_in, 0);

        rst = 1'b0;
        waitDutReset(low, saw_rsp);
        checkOutput("rst_low_cycles", low, 4);
        checkOutput("rst_done_op_ready", op_ready, 1);
        checkOutput("rst_done_ena", dut_ena, 1);

        applyStimulus(8'd3, 8'd4, lat);
        checkOutput("add_ui_in", seen_ui, 3);
        checkOutput("add_uio_in", seen_uio, 4);
        checkOutput("add_latency", lat, 4);
        checkOutput("add_rsp_data", rsp_data, 7);
        checkOutput("add_op_ready_busy", op_ready, 0);
        @(negedge clk);
        checkOutput("add_rsp_consumed", rsp_valid, 0);
        checkOutput("add_op_ready_back", op_ready, 1);

        applyStimulus(8'd200, 8'd100, lat);
        checkOutput("wrap_latency", lat, 4);
        checkOutput("wrap_rsp_data", rsp_data, 44);
`ifdef TT_HOST_CHECK_EN
        checkOutput("wrap_rsp_err", rsp_err, 0);
        checkOutput("wrap_err_count", err_count, 0);
`endif
        @(negedge clk);

        applyStimulus(8'hFF, 8'h01, lat);
        checkOutput("edge_rsp_data", rsp_data, 0);
        @(negedge clk);

        rsp_ready = 1'b0;
        applyStimulus(8'd10, 8'd20, lat);
        checkOutput("bp_latency", lat, 4);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd30 || op_ready !== 1'b0) stable = 1'b0;
        end
        checkOutput("bp_stable", stable, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_released_valid", rsp_valid, 0);
        checkOutput("bp_released_ready", op_ready, 1);

        dut_uio_oe = 8'hF0;
        applyStimulus(8'h01, 8'hFF, lat);
        checkOutput("mask_uio_in", seen_uio, 8'h0F);
        checkOutput("mask_rsp_data", rsp_data, 8'h10);
        dut_uio_oe = 8'h00;
        @(negedge clk);

        op_a     = 8'd9;
        op_b     = 8'd9;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_dut_rst_n", dut_rst_n, 0);
        checkOutput("midrst_dut_ena", dut_ena, 0);
        checkOutput("midrst_ui_in", dut_ui_in, 0);
        @(negedge clk);
        rst = 1'b0;
        waitDutReset(low, saw_rsp);
        checkOutput("midrst_low_cycles", low, 4);
        checkOutput("midrst_no_rsp", saw_rsp, 0);
        checkOutput("midrst_rsp_data", rsp_data, 0);
        checkOutput("midrst_op_ready", op_ready, 1);

`ifdef TT_HOST_CHECK_EN
        checkOutput("err_count_before", err_count, 0);
        corrupt = 1'b1;
        applyStimulus(8'd5, 8'd6, lat);
        checkOutput("err_rsp_data", rsp_data, 0);
        checkOutput("err_rsp_err", rsp_err, 1);
        checkOutput("err_count_after", err_count, 1);
        corrupt = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_host_sequencer.md
TT_HOST_SEQUENCER -- requirements
Module: tt_host_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4, number of cycles the DUT is held in reset after block reset.
REQ-002 SHALL have parameter LATENCY, default 2, number of cycles from operand drive to DUT output sample (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port op_valid, input, 1, operand pair offered.
REQ-006 SHALL have port op_ready, output, 1, operand pair accepted when op_valid and op_ready are both high.
REQ-007 SHALL have ports op_a and op_b, input, 8 each, the operands.
REQ-008 SHALL have port rsp_valid, output, 1, result available.
REQ-009 SHALL have port rsp_ready, input, 1, result consumed when rsp_valid and rsp_ready are both high.
REQ-010 SHALL have port rsp_data, output, 8, sampled DUT uo_out.
REQ-011 SHALL have ports dut_ena (output, 1), dut_rst_n (output, 1), dut_ui_in (output, 8), and dut_uio_in (output, 8), all driving the DUT pins.
REQ-012 SHALL have ports dut_uo_out, dut_uio_out, and dut_uio_oe, input, 8 each, sampled from the DUT pins.

Function
REQ-013 SHALL implement the FSM states DUT_RST, IDLE, DRIVE, WAIT, CAPTURE, and RESP.
REQ-014 SHALL stay in DUT_RST for RST_CYCLES cycles with dut_rst_n=0 and dut_ena=1, then enter IDLE with dut_rst_n=1.
REQ-015 SHALL assert op_ready only in IDLE; a handshake latches op_a and op_b and moves to DRIVE.
REQ-016 SHALL, in DRIVE, set dut_ui_in=op_a for one cycle, and set dut_uio_in bit i=op_b[i] where dut_uio_oe[i]=0 and 0 where dut_uio_oe[i]=1; it then moves to WAIT.
REQ-017 SHALL hold dut_ui_in and dut_uio_in stable from DRIVE until CAPTURE completes.
REQ-018 SHALL count LATENCY-1 cycles in WAIT and then move to CAPTURE; with LATENCY=1, WAIT lasts zero cycles.
REQ-019 SHALL register dut_uo_out into rsp_data in CAPTURE, so that the sample is taken exactly LATENCY cycles after the DRIVE cycle.
REQ-020 SHALL, in RESP, hold rsp_valid=1 and rsp_data stable until rsp_ready, then return to IDLE.
REQ-021 SHALL give the op-accept-to-rsp_valid latency as LATENCY+2 cycles.
REQ-022 SHALL keep op_ready low whenever rsp_valid is high, so that at most one transaction is in flight.
REQ-023 SHALL treat rsp_ready held high as zero-stall, giving a back-to-back throughput of one result per LATENCY+3 cycles.
REQ-024 SHALL ignore dut_uio_out for data purposes.

Reset
REQ-025 SHALL, on rst, asynchronously go to DUT_RST and set op_ready=0, rsp_valid=0, rsp_data=0, dut_ui_in=0, dut_uio_in=0, dut_rst_n=0, and dut_ena=0 (dut_ena rises on the first clock after release).
REQ-026 SHALL, on rst mid-transaction, discard the latched operands and any pending response, and re-run the DUT reset sequence.

Configuration
REQ-027 SHALL, with macro TT_HOST_CHECK_EN defined, compute the expected result (op_a+op_b) mod 256 at accept and compare it in CAPTURE.
REQ-028 SHALL, with TT_HOST_CHECK_EN defined, add output rsp_err (1 bit, valid with rsp_valid) and output err_count (8 bits, saturating at 255, reset 0).
REQ-029 SHALL, without TT_HOST_CHECK_EN, omit the expected-value register, the comparator, rsp_err, and err_count.

Structure
REQ-030 SHALL place the FSM state enum, the default RST_CYCLES and LATENCY constants, and the width constant 8 in package tt_host_pkg.
REQ-031 SHALL place the LATENCY/RST_CYCLES down-counter in one sub-module, tt_host_delay_cnt (load, tick, done), used by both DUT_RST and WAIT.

Verification
REQ-032 SHALL check the reset sequence: rst pulse -> dut_rst_n low for exactly 4 cycles, then op_ready=1.
REQ-033 SHALL check basic addition: op_a=3, op_b=4 with the DUT model returning the sum -> rsp_data=7, rsp_valid exactly 4 cycles (LATENCY=2) after accept.
REQ-034 SHALL check wrap-around: op_a=200, op_b=100 -> rsp_data=44; with TT_HOST_CHECK_EN, rsp_err=0.
REQ-035 SHALL check backpressure and masking: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, op_ready=0; then dut_uio_oe=0xF0, op_b=0xFF -> dut_uio_in=0x0F.
REQ-036 SHALL check reset mid-operation: rst asserted in WAIT -> no response is emitted and the DUT reset sequence repeats.
REQ-037 SHALL check error detection: with TT_HOST_CHECK_EN, the DUT model returns 0x00 for 5+6 -> rsp_err=1 and err_count increments from 0 to 1.
